// File: rtl/match_acc_pkg.sv
// Shared types and constants for the match accumulator slice.
package match_acc_pkg;

    // Default width of the match and beat counters.
    localparam int CNT_W_DEFAULT = 8;

    // Frame-level FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/match_acc_if.sv
// Beat input / frame result handshake bundle for the match accumulator.
interface match_acc_if #(
    parameter int CNT_W = 8
);

    logic             match_in;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] beat_cnt;
    logic             all_match;
    logic             any_match;
    logic             overflow;

    // Producer of beats and consumer of results.
    modport master (
        output match_in, in_valid, in_last, out_ready,
        input  in_ready, out_valid, match_cnt, beat_cnt, all_match, any_match, overflow
    );

    // The accumulator itself.
    modport slave (
        input  match_in, in_valid, in_last, out_ready,
        output in_ready, out_valid, match_cnt, beat_cnt, all_match, any_match, overflow
    );

endinterface

// File: rtl/match_accumulator_sat_counter.sv
// Saturating up-counter with a parallel load; never wraps past all-ones.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    assign sat = (count == {CNT_W{1'b1}});

    // Load starts a new frame's count; increments stop at the ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/match_accumulator.sv
// Counts matching beats across a frame and presents the frame summary
// on a valid/ready result port, holding it until the consumer takes it.
module match_accumulator
    import match_acc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input logic        clk,
    input logic        rst,
    match_acc_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_HOLD  = HOLD;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             all_q;
    logic             any_q;
    logic             ovf_q;
    logic             accept;
    logic             first_beat;
    logic             more_beat;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] beat_count;
    logic             match_sat;
    logic             beat_sat;

    assign accept     = bus.in_valid && in_ready_q;
    assign first_beat = accept && (state == ST_IDLE);
    assign more_beat  = accept && (state == ST_ACCUM);

    // Next-state selection: beats move toward HOLD, the consumer releases HOLD.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    next_state = bus.in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register with handshake flags decoded from the upcoming state,
    // so in_ready stays low through reset and rises on the first clock after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= next_state;
            in_ready_q  <= (next_state != ST_HOLD);
            out_valid_q <= (next_state == ST_HOLD);
        end
    end

    // Frame flags: reloaded on a frame's first beat, folded on later beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_q <= 1'b0;
            any_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (first_beat) begin
            all_q <= bus.match_in;
            any_q <= bus.match_in;
            ovf_q <= 1'b0;
        end else if (more_beat) begin
            all_q <= all_q & bus.match_in;
            any_q <= any_q | bus.match_in;
            if (beat_sat) begin
                ovf_q <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (first_beat),
        .load_val ({{(CNT_W-1){1'b0}}, bus.match_in}),
        .inc      (more_beat && bus.match_in),
        .count    (match_count),
        .sat      (match_sat)
    );

    sat_counter #(.CNT_W(CNT_W)) u_beat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (first_beat),
        .load_val ({{(CNT_W-1){1'b0}}, 1'b1}),
        .inc      (more_beat),
        .count    (beat_count),
        .sat      (beat_sat)
    );

    logic unused_match_sat;
    assign unused_match_sat = match_sat;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.match_cnt = match_count;
    assign bus.beat_cnt  = beat_count;
    assign bus.all_match = all_q;
    assign bus.any_match = any_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_match_accumulator.sv
// Randomized self-checking bench for match_accumulator with a frame-level model.
module tb_match_accumulator;

    localparam int CNT_W = 8;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    match_acc_if #(.CNT_W(CNT_W)) bus ();

    match_accumulator #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors;
    int miscompares;
    bit frame_bits[$];
    int exp_match;
    int exp_beat;
    int exp_all;
    int exp_any;
    int exp_ovf;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the DUT stalls the whole run.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input longint got, input longint expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
        end
    endtask

    // Frame summary computed directly from the list of match bits.
    task automatic computeExpected();
        int n;
        int ones;
        n = frame_bits.size();
        ones = 0;
        exp_all = 1;
        exp_any = 0;
        foreach (frame_bits[i]) begin
            ones += int'(frame_bits[i]);
            if (!frame_bits[i]) exp_all = 0;
            if (frame_bits[i])  exp_any = 1;
        end
        exp_beat  = (n > MAX) ? MAX : n;
        exp_match = (ones > MAX) ? MAX : ones;
        exp_ovf   = (n > MAX) ? 1 : 0;
    endtask

    task automatic checkResult(input string tag);
        checkOutput({tag, ".out_valid"}, bus.out_valid, 1);
        checkOutput({tag, ".match_cnt"}, bus.match_cnt, exp_match);
        checkOutput({tag, ".beat_cnt"},  bus.beat_cnt,  exp_beat);
        checkOutput({tag, ".all_match"}, bus.all_match, exp_all);
        checkOutput({tag, ".any_match"}, bus.any_match, exp_any);
        checkOutput({tag, ".overflow"},  bus.overflow,  exp_ovf);
    endtask

    // Drive every beat of frame_bits with optional idle gaps; ends at the
    // negedge right after the last beat was accepted.
    task automatic applyStimulus(input int gap_max);
        int n;
        int gaps;
        int waited;
        n = frame_bits.size();
        for (int i = 0; i < n; i++) begin
            gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            repeat (gaps) begin
                @(negedge clk);
                bus.in_valid  = 1'b0;
                bus.match_in  = 1'($urandom);
                bus.in_last   = 1'($urandom);
                bus.out_ready = 1'($urandom);
            end
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.match_in  = frame_bits[i];
            bus.in_last   = (i == n - 1);
            bus.out_ready = 1'($urandom);
            waited = 0;
            while (!bus.in_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (!bus.in_ready) checkOutput("accept_timeout", bus.in_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // Stall the consumer, verify the result is frozen, then release it.
    task automatic releaseResult(input string tag, input int hold);
        repeat (hold) begin
            @(negedge clk);
            checkOutput({tag, ".hold_in_ready"}, bus.in_ready, 0);
            checkResult({tag, ".hold"});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, ".done_out_valid"}, bus.out_valid, 0);
        checkOutput({tag, ".done_in_ready"},  bus.in_ready,  1);
        checkOutput({tag, ".idle_beat_cnt"},  bus.beat_cnt,  exp_beat);
        checkOutput({tag, ".idle_match_cnt"}, bus.match_cnt, exp_match);
    endtask

    task automatic runFrame(input string tag, input int gap_max, input int hold);
        computeExpected();
        applyStimulus(gap_max);
        checkResult(tag);
        releaseResult(tag, hold);
    endtask

    task automatic checkZeroed(input string tag);
        checkOutput({tag, ".in_ready"},  bus.in_ready,  0);
        checkOutput({tag, ".out_valid"}, bus.out_valid, 0);
        checkOutput({tag, ".match_cnt"}, bus.match_cnt, 0);
        checkOutput({tag, ".beat_cnt"},  bus.beat_cnt,  0);
        checkOutput({tag, ".all_match"}, bus.all_match, 0);
        checkOutput({tag, ".any_match"}, bus.any_match, 0);
        checkOutput({tag, ".overflow"},  bus.overflow,  0);
    endtask

    initial begin
        int len;
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b0;
        bus.match_in  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        #3 rst = 1'b1;
        #1 checkZeroed("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset.in_ready", bus.in_ready, 1);

        // Four beats 1,0,1,1.
        frame_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        runFrame("four_beat", 0, 0);

        // Same frame with idle gaps must give identical counts.
        frame_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        runFrame("four_beat_gaps", 3, 0);

        // Single-beat frame.
        frame_bits = '{1'b1};
        runFrame("single", 0, 0);

        // All-zero frame held by a stalled consumer.
        frame_bits = '{1'b0, 1'b0, 1'b0};
        runFrame("stall", 0, 5);

        // Saturation: 300 matching beats.
        frame_bits.delete();
        repeat (300) frame_bits.push_back(1'b1);
        runFrame("saturate", 0, 1);

        // Reset in the middle of a frame discards it.
        frame_bits = '{1'b1, 1'b1};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.match_in = frame_bits[i];
            bus.in_last  = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1 checkZeroed("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_reset.out_valid_after", bus.out_valid, 0);
        checkOutput("mid_reset.in_ready_after",  bus.in_ready,  1);
        frame_bits = '{1'b0, 1'b1};
        runFrame("after_reset", 0, 0);

        // Random frames, occasionally long enough to reach saturation.
        for (int f = 0; f < 40; f++) begin
            frame_bits.delete();
            len = ($urandom_range(7, 0) == 0) ? $urandom_range(270, 250) : $urandom_range(12, 1);
            for (int b = 0; b < len; b++) begin
                frame_bits.push_back(($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0);
            end
            runFrame("random", 2, $urandom_range(4, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
